// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a byte-fetch multicycle MIPS subset (LB, SB, R-type, BEQ, J).
// Define MULTICYCLE_CTRL_ADDI_EN to add the ADDI execute/writeback states.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       iord,
  output logic       regdst,
  output logic       regwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [3:0] irwrite,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12
`ifdef MULTICYCLE_CTRL_ADDI_EN
    ,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
`endif
  } state_t;

  state_t     cur, nxt;
  logic [1:0] aluop;
  logic       pcwrite, pcwritecond;
  logic       memread_d, memwrite_d, regwrite_d;
  logic [3:0] irwrite_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= FETCH1;
    else        cur <= nxt;
  end

  always_comb begin
    nxt         = FETCH1;
    memread_d   = 1'b0;
    memwrite_d  = 1'b0;
    regwrite_d  = 1'b0;
    irwrite_d   = 4'b0000;
    alusrca     = 1'b0;
    memtoreg    = 1'b0;
    iord        = 1'b0;
    regdst      = 1'b0;
    pcsrc       = 2'b00;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    case (cur)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread_d = 1'b1;
        alusrcb   = 2'b01;
        pcwrite   = 1'b1;
        irwrite_d = 4'b0001 << cur[1:0];
        nxt       = (cur == FETCH4) ? DECODE : state_t'(cur + 4'd1);
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100000, 6'b101000: nxt = MEMADR;
          6'b000000:            nxt = RTYPEEX;
          6'b000100:            nxt = BEQEX;
          6'b000010:            nxt = JEX;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          6'b001000:            nxt = ADDIEX;
`endif
          default:              nxt = FETCH1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (op == 6'b100000) ? LBRD : SBWR;
      end
      LBRD: begin
        memread_d = 1'b1;
        iord      = 1'b1;
        nxt       = LBWR;
      end
      LBWR: begin
        regwrite_d = 1'b1;
        memtoreg   = 1'b1;
      end
      SBWR: begin
        memwrite_d = 1'b1;
        iord       = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        nxt     = RTYPEWR;
      end
      RTYPEWR: begin
        regwrite_d = 1'b1;
        regdst     = 1'b1;
      end
      BEQEX: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcsrc       = 2'b01;
        pcwritecond = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = ADDIWR;
      end
      ADDIWR: begin
        regwrite_d = 1'b1;
      end
`endif
      default: nxt = FETCH1;
    endcase
  end

  always_comb begin
    case (aluop)
      2'b01:   alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b101;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Write strobes are held off for as long as reset is low, not just until the state settles.
  assign memread  = memread_d & reset;
  assign memwrite = memwrite_d & reset;
  assign regwrite = regwrite_d & reset;
  assign irwrite  = irwrite_d & {4{reset}};
  assign pcen     = (pcwrite | (pcwritecond & zero)) & reset;
  assign state    = cur;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port op, input, 6 bits: opcode, instr[31:26] from the datapath instruction register.
REQ-004 The block SHALL have port funct, input, 6 bits: function field, instr[5:0].
REQ-005 The block SHALL have port zero, input, 1 bit: ALU zero flag from the datapath.
REQ-006 The block SHALL have outputs memread and memwrite, 1 bit each: memory strobes.
REQ-007 The block SHALL have outputs alusrca, memtoreg, iord, regdst, regwrite and pcen, 1 bit each: datapath selects and enables.
REQ-008 The block SHALL have outputs pcsrc and alusrcb, 2 bits each: datapath mux selects.
REQ-009 The block SHALL have output irwrite, 4 bits: one-hot byte enable for the 32-bit IR; bit0 loads instr[7:0].
REQ-010 The block SHALL have output alucontrol, 3 bits: ALU operation.
REQ-011 The block SHALL have output state, 4 bits: current FSM state, for debug.

Function
REQ-012 The block SHALL be a Moore FSM; every output SHALL be decoded from state only, except pcen and alucontrol.
REQ-013 The FSM SHALL use these state encodings: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12. ADDIEX=13 and ADDIWR=14 exist only when ADDI_EN is defined (REQ-029).
REQ-014 FETCH1..FETCH4 SHALL advance unconditionally in order, FETCH4 going to DECODE; each fetch state drives memread=1, alusrcb=01, pcsrc=00, internal pcwrite=1, and irwrite=0001/0010/0100/1000 respectively.
REQ-015 In DECODE the block SHALL drive alusrcb=11 and branch on op: 100000 (LB) or 101000 (SB) go to MEMADR; 000000 go to RTYPEEX; 000100 go to BEQEX; 000010 go to JEX; any other value goes to FETCH1 with no write enable asserted.
REQ-016 In MEMADR the block SHALL drive alusrca=1 and alusrcb=10; op=100000 goes to LBRD, otherwise SBWR.
REQ-017 The load and store states SHALL drive: LBRD memread=1, iord=1, then LBWR; LBWR regwrite=1, memtoreg=1, regdst=0, then FETCH1; SBWR memwrite=1, iord=1, then FETCH1.
REQ-018 The R-type states SHALL drive: RTYPEEX alusrca=1, alusrcb=00, aluop=10, then RTYPEWR; RTYPEWR regwrite=1, regdst=1, memtoreg=0, then FETCH1.
REQ-019 BEQEX SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, internal pcwritecond=1, then go to FETCH1.
REQ-020 JEX SHALL drive pcsrc=10 and pcwrite=1, then go to FETCH1.
REQ-021 pcen SHALL equal pcwrite OR (pcwritecond AND zero), combinational in the current cycle.
REQ-022 All outputs not listed for a state SHALL be 0; aluop SHALL be 00 unless listed.
REQ-023 alucontrol SHALL be set as follows: for aluop 00, 010 (add); for aluop 01, 110 (sub); for aluop 10, decoded from funct as 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, and any other funct->101.
REQ-024 Instruction latency SHALL be: LB 8 cycles, SB 7, R-type 7, BEQ 6, J 6, illegal opcode 5, each counted from FETCH1 entry to the next FETCH1.
REQ-025 Encodings 13-15 that are not implemented SHALL go to FETCH1 on the next edge with all outputs 0.

Reset
REQ-026 When reset=0, state SHALL go to FETCH1 immediately, asynchronously, including mid-instruction.
REQ-027 While reset=0, pcen, regwrite, memwrite, memread and irwrite SHALL be forced to 0; the other outputs SHALL show FETCH1 decode values, with alusrcb=01 and alucontrol=010.
REQ-028 On the first rising clk edge after reset deasserts, the block SHALL execute FETCH1 with its full enables (irwrite=0001, pcen=1) and advance to FETCH2.

Configuration
REQ-029 When macro MULTICYCLE_CTRL_ADDI_EN is defined, op=001000 in DECODE SHALL go to ADDIEX (alusrca=1, alusrcb=10, aluop=00) and then ADDIWR (regwrite=1, regdst=0, memtoreg=0), then FETCH1; ADDI latency SHALL be 7 cycles.
REQ-030 When MULTICYCLE_CTRL_ADDI_EN is undefined, op=001000 SHALL be illegal per REQ-015, and states 13/14 SHALL behave per REQ-025.

Verification
REQ-031 The bench SHALL check this scenario: reset=0 for 2 cycles, then release -> state=0 and irwrite=0000 during reset; irwrite sequence 0001, 0010, 0100, 1000, then state=4 with alusrcb=11.
REQ-032 The bench SHALL check this scenario: op=000000, funct=100000 -> RTYPEEX with alucontrol=010, alusrca=1, then RTYPEWR with regwrite=1, regdst=1, back at FETCH1 after 7 cycles.
REQ-033 The bench SHALL check this scenario: op=000100 with zero=1, then repeated with zero=0 -> pcen=1 in BEQEX, alucontrol=110, pcsrc=01; pcen=0 in BEQEX.
REQ-034 The bench SHALL check this scenario: op=100000, then op=101000 -> LB visits 4,5,6,7 with LBWR regwrite=1, memtoreg=1; SB visits 4,5,8 with memwrite=1, iord=1, regwrite=0.
REQ-035 The bench SHALL check this scenario: op=111111, then op=001000 under each macro setting -> DECODE then FETCH1 with no enables; ADDI gives state 13 then 14 with regwrite=1 only when MULTICYCLE_CTRL_ADDI_EN is defined, otherwise it is illegal.
REQ-036 The bench SHALL check this scenario: reset=0 asserted asynchronously in RTYPEWR between clock edges -> state=0 and regwrite=0 before the next clk edge.
